mips_data_bridge: RTL

Stalling bridge between the Harvard CPU's data port and a wait-stated, Avalon-style data memory. The CPU data port expects combinational reads and single-cycle writes. This block turns each CPU data request into a registered bus transaction and holds the CPU by dropping its clock enable until the transaction completes. It sits directly downstream of the CPU data port, between the CPU and the data RAM or interconnect.

---
 rtl/mips_data_bridge_if.sv | 21 ++
 rtl/mips_data_bridge.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mips_data_bridge_if.sv
// Avalon-style data bus between the bridge (master) and data memory (slave).
// Latency: none, wires only.
// Backpressure: slave stalls the master with mem_waitrequest.
interface mips_data_bridge_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    modport master (
        output mem_address, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_waitrequest
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_waitrequest
    );
endinterface

// File: rtl/mips_data_bridge.sv
// Stalling bridge from the CPU data port to a wait-stated Avalon-style data memory.
// Latency: 3 cycles for a zero-wait access (+1 per waitrequest cycle), 2 for a misaligned abort.
// Backpressure: CPU is frozen via cpu_clk_enable; bus strobes are held while mem_waitrequest=1.
module mips_data_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run_enable,
    output logic                       cpu_clk_enable,
    input  logic [31:0]                data_address,
    input  logic                       data_read,
    input  logic                       data_write,
    input  logic [31:0]                data_writedata,
    output logic [31:0]                data_readdata,
    mips_data_bridge_if.master         mem,
    output logic [2:0]                 bus_error,
    output logic [31:0]                stall_count
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  err_q, err_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] wait_q, wait_d;

    assign mem.mem_address   = addr_q;
    assign mem.mem_read      = rd_q;
    assign mem.mem_write     = wr_q;
    assign mem.mem_writedata = wdata_q;
    assign data_readdata     = result_q;
    assign bus_error         = err_q;
    assign stall_count       = stall_q;

    // Next-state, bus strobes, error flags and the CPU clock enable.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rd_d           = rd_q;
        wr_d           = wr_q;
        result_d       = result_q;
        err_d          = err_q;
        wait_d         = wait_q;
        cpu_clk_enable = run_enable;

        case (state_q)
            IDLE: begin
                if (data_read || data_write) begin
                    // Freeze the CPU the moment it asks; latch only when the system runs.
                    cpu_clk_enable = 1'b0;
                    if (run_enable) begin
                        wait_d = 32'd0;
                        if (data_address[1:0] != 2'b00) begin
                            err_d[1] = 1'b1;
                            result_d = ERR_DATA;
                            state_d  = DONE;
                        end else if (data_write) begin
                            addr_d  = {data_address[31:2], 2'b00};
                            wdata_d = data_writedata;
                            wr_d    = 1'b1;
                            state_d = WRITE;
                            if (data_read) begin
                                err_d[2] = 1'b1;
                            end
                        end else begin
                            addr_d  = {data_address[31:2], 2'b00};
                            rd_d    = 1'b1;
                            state_d = READ;
                        end
                    end
                end
            end
            READ, WRITE: begin
                // Bus protocol wins over run_enable: strobes stay up until accepted.
                cpu_clk_enable = 1'b0;
                if (!mem.mem_waitrequest) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = DONE;
                    if (state_q == READ) begin
                        result_d = mem.mem_readdata;
                    end
                end else begin
                    wait_d = wait_q + 32'd1;
                    if ((TIMEOUT_CYCLES != 0) && (wait_d == TIMEOUT_CYCLES)) begin
                        rd_d     = 1'b0;
                        wr_d     = 1'b0;
                        err_d[0] = 1'b1;
                        result_d = ERR_DATA;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                // Leave only on the edge where the CPU actually commits.
                if (run_enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_d = stall_q;
        if (run_enable && !cpu_clk_enable && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // State and datapath registers; reset clears everything, even mid-transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            result_q <= 32'd0;
            err_q    <= 3'b000;
            stall_q  <= 32'd0;
            wait_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            result_q <= result_d;
            err_q    <= err_d;
            stall_q  <= stall_d;
            wait_q   <= wait_d;
        end
    end

endmodule
